c3aibadapt_cmn_occ_burst_ctrl: RTL
==================================

// Module: c3aibadapt_cmn_occ_burst_ctrl
// PURPOSE
//  Upstream control stage for the OCC enable logic of one user_clk domain: holds the per-domain
//  OCC config, loaded serially during scan shift. It generates the occ_enable launch edge and a
//  stable burst_cnt for each ATPG capture window. It also reports busy/done so the tester-side
//  sequencer knows when the capture burst has finished.
// PARAMETERS
//  SYNC_STAGES  3  sync depth of the downstream enable synchroniser; used only in the done timing
//  DLY_W        4  width of the launch-delay field (cycles of user_clk)
// PORTS
//  user_clk       in   1      domain clock (free-running during capture)
//  reset          in   1      asynchronous, active-low reset
//  atpg_mode      in   1      1 = ATPG active; 0 = block idle, outputs forced inactive
//  scan_enable    in   1      scan shift pin (asynchronous to user_clk)
//  cfg_shift_en   in   1      shift enable for the config chain
//  cfg_shift_in   in   1      serial config in (LSB first)
//  cfg_shift_out  out  1      serial config out (MSB of the shift register)
//  test_trigger   in   1      tester capture trigger (asynchronous, level)
//  burst_cnt      out  2      gray-coded burst target to the OCC enable logic
//  occ_enable     out  1      launch edge to the OCC enable logic (rising edge is significant)
//  busy           out  1      burst in progress (DELAY/FIRE)
//  done           out  1      capture burst complete; held until scan_enable reasserts
// BEHAVIOUR
//  Reset: all flops 0 except the scan_enable sync flops (1); all outputs 0.
//  Sync: scan_enable -> se_s (2 flops, reset 1); test_trigger -> trg_s (2 flops) + rise detect.
//  Config shift reg (8b, {DLY_W+4}):
//   - shifts when cfg_shift_en & scan_enable (raw) on the user_clk rising edge: sr <= {sr[6:0],cfg_shift_in}
//   - shift-in order is LSB first; cfg_shift_out = sr[7]
//   - field map: [1:0] burst_cnt, [5:2] launch_dly, [6] dom_en, [7] auto_trig
//  Shadow: copied from sr on the first cycle se_s is 0 after having been 1. burst_cnt = shadow[1:0].
//   The shadow is stable for the whole capture window. Shift activity while se_s=0 is ignored.
//  Pulse count N is decoded from the gray burst_cnt: 00->0, 01->1, 11->2, 10->3.
//  FSM: IDLE, ARM, DELAY, FIRE, DONE
//   IDLE : wait for se_s to fall, then load the shadow.
//          dom_en=0 or N=0 -> DONE (no occ_enable edge).
//          Otherwise -> ARM.
//   ARM  : auto_trig=1 -> DELAY at once. Otherwise wait for the trg_s rising edge -> DELAY.
//   DELAY: down-counter loaded with launch_dly; on count 0 -> FIRE. Delay 0 gives 1 cycle in DELAY.
//   FIRE : occ_enable=1 (registered; held until exit to IDLE).
//          Wait counter = SYNC_STAGES+N+1 cycles, then -> DONE.
//   DONE : done=1 and occ_enable stays 1; leave only on se_s=1.
//  busy = state in {DELAY, FIRE}.
//  Any state with se_s=1 -> IDLE next cycle: occ_enable, busy and done go to 0 and the counters clear.
//   This covers scan reassertion mid-burst.
//  atpg_mode=0: FSM held in IDLE, occ_enable=0, burst_cnt=00, done=0. The shift reg still shifts.
//  Trigger edges outside ARM are ignored; only one burst per capture window.
//  A trigger edge coincident with entry to ARM is honoured.
//  Reset mid-operation: asynchronous return to reset values; occ_enable falls immediately.
// TESTING
//  1. Shift 8'b1100_0110 (auto, en, dly=1, burst=10); drop scan_enable.
//     -> burst_cnt=10 and occ_enable rises 2 cycles after ARM; done 7 cycles later (3+3+1).
//  2. auto_trig=0, burst=01, dly=0: occ_enable stays 0 until test_trigger rises.
//     -> rises 4 cycles after the trigger (2 sync + edge + DELAY); done 5 cycles later.
//  3. dom_en=0 or burst=00 -> straight to DONE, occ_enable never toggles, busy stays 0.
//  4. Reassert scan_enable while in FIRE -> within 3 cycles occ_enable=0, done=0, state IDLE.
//     A following window re-fires correctly.
//  5. atpg_mode=0 with a valid config and scan_enable low -> occ_enable=0, burst_cnt=00 throughout.
//     cfg_shift_out still echoes cfg_shift_in delayed 8 shift cycles.
//  6. Assert reset mid-DELAY -> all outputs 0 at once; after release the block idles until the next shift/capture.

Source files
------------

// File: rtl/c3aibadapt_cmn_occ_burst_ctrl_if.sv
// Signal bundle between the tester-side sequencer (master) and the OCC burst
// control stage (slave). Clock and reset stay as plain ports on the module.
interface c3aibadapt_cmn_occ_burst_ctrl_if;
  logic       atpg_mode;
  logic       scan_enable;
  logic       cfg_shift_en;
  logic       cfg_shift_in;
  logic       cfg_shift_out;
  logic       test_trigger;
  logic [1:0] burst_cnt;
  logic       occ_enable;
  logic       busy;
  logic       done;

  // Tester / sequencer side: drives mode, scan and trigger, observes status.
  modport master (
    output atpg_mode,
    output scan_enable,
    output cfg_shift_en,
    output cfg_shift_in,
    output test_trigger,
    input  cfg_shift_out,
    input  burst_cnt,
    input  occ_enable,
    input  busy,
    input  done
  );

  // Burst control block side.
  modport slave (
    input  atpg_mode,
    input  scan_enable,
    input  cfg_shift_en,
    input  cfg_shift_in,
    input  test_trigger,
    output cfg_shift_out,
    output burst_cnt,
    output occ_enable,
    output busy,
    output done
  );
endinterface

// File: rtl/c3aibadapt_cmn_occ_burst_ctrl.sv
// OCC burst control for one user_clk domain. A serially loaded config word is
// frozen into a shadow when scan shift ends; the FSM then optionally waits for
// a tester trigger, counts a launch delay, raises occ_enable and finally
// reports done once the downstream enable synchroniser and the burst itself
// have had time to complete.
module c3aibadapt_cmn_occ_burst_ctrl #(
  parameter int SYNC_STAGES = 3,
  parameter int DLY_W       = 4
) (
  input  logic                                 user_clk,
  input  logic                                 reset,
  c3aibadapt_cmn_occ_burst_ctrl_if.slave       bus
);

  // Config word: [1:0] burst (gray), [DLY_W+1:2] launch delay,
  // [DLY_W+2] domain enable, [DLY_W+3] auto trigger.
  localparam int SR_W     = DLY_W + 4;
  localparam int DOMEN_B  = DLY_W + 2;
  localparam int AUTO_B   = DLY_W + 3;
  // The shared counter must hold both the launch delay and the FIRE wait
  // (at most SYNC_STAGES + 3).
  localparam int WAIT_W   = $clog2(SYNC_STAGES + 5);
  localparam int CNT_W    = (DLY_W > WAIT_W) ? DLY_W : WAIT_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    DELAY = 3'd2,
    FIRE  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Gray burst code to pulse count: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_to_count(input logic [1:0] g);
    gray_to_count = {g[1], g[1] ^ g[0]};
  endfunction

  // Synchronisers and edge history.
  logic             se_meta_reg;
  logic             se_s_reg;
  logic             se_prev_reg;
  logic             trg_meta_reg;
  logic             trg_s_reg;
  logic             trg_prev_reg;

  // Config chain and its frozen copy.
  logic [SR_W-1:0]  sr_reg;
  logic             scan_seen_reg;
  logic [1:0]       shadow_burst_reg;
  logic [DLY_W-1:0] shadow_dly_reg;
  logic             shadow_auto_reg;

  // FSM.
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             trg_pend_reg;
  logic             trg_pend_next;
  logic             occ_enable_reg;
  logic             occ_enable_next;
  logic             busy_reg;
  logic             busy_next;
  logic             done_reg;
  logic             done_next;

  logic             shift_en;
  logic             se_fall;
  logic             capture_start;
  logic             trg_rise;
  logic [1:0]       sr_count;
  logic [1:0]       shadow_count;

  // Shifting uses the raw scan pin: the chain is clocked only while the
  // tester is actively shifting, so no synchronisation is needed here.
  assign shift_en      = bus.cfg_shift_en & bus.scan_enable;
  assign se_fall       = se_prev_reg & ~se_s_reg;
  // After reset the chain is empty; a capture window only counts once
  // something has actually been shifted in.
  assign capture_start = se_fall & scan_seen_reg;
  assign trg_rise      = trg_s_reg & ~trg_prev_reg;
  assign sr_count      = gray_to_count(sr_reg[1:0]);
  assign shadow_count  = gray_to_count(shadow_burst_reg);

  // Two-flop scan_enable synchroniser plus history; resets as "in shift".
  always_ff @(posedge user_clk or negedge reset) begin
    if (!reset) begin
      se_meta_reg <= 1'b1;
      se_s_reg    <= 1'b1;
      se_prev_reg <= 1'b1;
    end else begin
      se_meta_reg <= bus.scan_enable;
      se_s_reg    <= se_meta_reg;
      se_prev_reg <= se_s_reg;
    end
  end

  // Two-flop test_trigger synchroniser plus history for rise detection.
  always_ff @(posedge user_clk or negedge reset) begin
    if (!reset) begin
      trg_meta_reg <= 1'b0;
      trg_s_reg    <= 1'b0;
      trg_prev_reg <= 1'b0;
    end else begin
      trg_meta_reg <= bus.test_trigger;
      trg_s_reg    <= trg_meta_reg;
      trg_prev_reg <= trg_s_reg;
    end
  end

  // Serial config chain; new bits enter at bit 0, bit SR_W-1 is echoed out.
  always_ff @(posedge user_clk or negedge reset) begin
    if (!reset) begin
      sr_reg        <= '0;
      scan_seen_reg <= 1'b0;
    end else if (shift_en) begin
      sr_reg        <= {sr_reg[SR_W-2:0], bus.cfg_shift_in};
      scan_seen_reg <= 1'b1;
    end
  end

  // Freeze the config at the start of each capture window.
  always_ff @(posedge user_clk or negedge reset) begin
    if (!reset) begin
      shadow_burst_reg <= 2'b00;
      shadow_dly_reg   <= '0;
      shadow_auto_reg  <= 1'b0;
    end else if (capture_start) begin
      shadow_burst_reg <= sr_reg[1:0];
      shadow_dly_reg   <= sr_reg[DLY_W+1:2];
      shadow_auto_reg  <= sr_reg[AUTO_B];
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    trg_pend_next   = 1'b0;

    if (!bus.atpg_mode || se_s_reg) begin
      // Idle mode or scan active (including reassertion mid-burst).
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (capture_start) begin
            // Decide from the chain directly: the shadow loads this same edge.
            if (!sr_reg[DOMEN_B] || (sr_count == 2'd0)) begin
              state_next = DONE;
            end else begin
              state_next    = ARM;
              // Keep a trigger edge that lands on the ARM entry edge.
              trg_pend_next = trg_rise;
            end
          end
        end
        ARM: begin
          if (shadow_auto_reg || trg_rise || trg_pend_reg) begin
            state_next = DELAY;
            cnt_next   = CNT_W'(shadow_dly_reg);
          end
        end
        DELAY: begin
          if (cnt_reg == '0) begin
            state_next = FIRE;
            // FIRE lasts SYNC_STAGES + N + 1 cycles, so load one less.
            cnt_next   = CNT_W'(SYNC_STAGES) + CNT_W'(shadow_count);
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        FIRE: begin
          if (cnt_reg == '0) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    // occ_enable rises on FIRE entry and is held through DONE; a burst that
    // skipped FIRE reaches DONE with occ_enable still low.
    occ_enable_next = (state_next == FIRE) ||
                      ((state_next == DONE) && occ_enable_reg);
    busy_next       = (state_next == DELAY) || (state_next == FIRE);
    done_next       = (state_next == DONE);
  end

  // State, counter and glitch-free registered outputs.
  always_ff @(posedge user_clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      trg_pend_reg   <= 1'b0;
      occ_enable_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      trg_pend_reg   <= trg_pend_next;
      occ_enable_reg <= occ_enable_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign bus.cfg_shift_out = sr_reg[SR_W-1];
  assign bus.burst_cnt     = bus.atpg_mode ? shadow_burst_reg : 2'b00;
  assign bus.occ_enable    = occ_enable_reg;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;

endmodule
